// File: rtl/cpu_mem_pkg.sv
// Shared constants and helpers for the CPU-side memory blocks.
package cpu_mem_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] MIPS_NOP = 32'h0000_0000;

  // Number of byte-index bits for a power-of-two byte capacity.
  function automatic int idx_w(input int depth_bytes);
    return $clog2(depth_bytes);
  endfunction

endpackage

// File: rtl/imem_fetch_port_if.sv
// Fetch request/response handshake between the fetch stage (master) and
// the instruction store (slave).
interface imem_fetch_port_if #(
  parameter int ADDR_W = 32
);
  import cpu_mem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WORD_W-1:0] rsp_inst;
  logic              rsp_misaligned;
  logic              rsp_oob;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_inst, rsp_misaligned, rsp_oob
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_inst, rsp_misaligned, rsp_oob
  );

endinterface

// File: rtl/imem_byte_array.sv
// Byte-wide instruction RAM: one byte write port, combinational little-endian
// word read at an aligned base. Contents are deliberately not reset.
module imem_byte_array
  import cpu_mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 4096,
  localparam int IDX_W      = idx_w(DEPTH_BYTES)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic [IDX_W-3:0]  rd_word,
  output logic [WORD_W-1:0] rd_data
);

  logic [BYTE_W-1:0] mem [DEPTH_BYTES];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = {mem[{rd_word, 2'd3}], mem[{rd_word, 2'd2}],
                    mem[{rd_word, 2'd1}], mem[{rd_word, 2'd0}]};

endmodule

// File: rtl/imem_fetch_port.sv
// Instruction store with a registered one-cycle fetch pipeline, valid/ready
// on both sides, misalign/out-of-range flags and a byte load port.
module imem_fetch_port
  import cpu_mem_pkg::*;
#(
  parameter int              ADDR_W      = 32,
  parameter int              DEPTH_BYTES = 4096,
  parameter logic [WORD_W-1:0] FAULT_INST = MIPS_NOP
) (
  input  logic              clk,
  input  logic              rst_n,
  imem_fetch_port_if.slave  bus,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [BYTE_W-1:0] ld_data,
  output logic [31:0]       fetch_count
);

  localparam int IDX_W = idx_w(DEPTH_BYTES);

  logic              req_oob;
  logic              ld_oob;
  logic              accept;
  logic [WORD_W-1:0] ram_word;

  logic              rsp_valid_q, rsp_valid_d;
  logic [WORD_W-1:0] rsp_inst_q, rsp_inst_d;
  logic              rsp_mis_q, rsp_mis_d;
  logic              rsp_oob_q, rsp_oob_d;
  logic [31:0]       fetch_count_q, fetch_count_d;

  assign req_oob = (bus.req_addr >> IDX_W) != '0;
  assign ld_oob  = (ld_addr >> IDX_W) != '0;

  // A load owns the cycle, so a fetch never races a write to the same word.
  assign bus.req_ready = !ld_en && (!rsp_valid_q || bus.rsp_ready);
  assign accept        = bus.req_valid && bus.req_ready;

  imem_byte_array #(
    .DEPTH_BYTES (DEPTH_BYTES)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ld_en && !ld_oob),
    .wr_addr (ld_addr[IDX_W-1:0]),
    .wr_data (ld_data),
    .rd_word (bus.req_addr[IDX_W-1:2]),
    .rd_data (ram_word)
  );

  always_comb begin
    rsp_valid_d   = rsp_valid_q;
    rsp_inst_d    = rsp_inst_q;
    rsp_mis_d     = rsp_mis_q;
    rsp_oob_d     = rsp_oob_q;
    fetch_count_d = fetch_count_q;
    if (accept) begin
      rsp_valid_d   = 1'b1;
      rsp_inst_d    = req_oob ? FAULT_INST : ram_word;
      rsp_mis_d     = bus.req_addr[1:0] != 2'b00;
      rsp_oob_d     = req_oob;
      fetch_count_d = fetch_count_q + 32'd1;
    end else if (bus.rsp_ready) begin
      // Payload fields hold their last value; only valid drops.
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q   <= 1'b0;
      rsp_inst_q    <= '0;
      rsp_mis_q     <= 1'b0;
      rsp_oob_q     <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      rsp_valid_q   <= rsp_valid_d;
      rsp_inst_q    <= rsp_inst_d;
      rsp_mis_q     <= rsp_mis_d;
      rsp_oob_q     <= rsp_oob_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_inst       = rsp_inst_q;
  assign bus.rsp_misaligned = rsp_mis_q;
  assign bus.rsp_oob        = rsp_oob_q;
  assign fetch_count        = fetch_count_q;

endmodule
